fifo_n_guarded: RTL

Parametrised N-entry guarded FIFO, the multi-entry successor to the one-element `Fifo1` channel used between generated modules. It presents the same guarded-method interface: `in$enq`, `out$deq`, `out$first`, each with `__ENA`/`__RDY` strobes. It adds configurable data width and depth, an occupancy output, and an optional pipelined mode that accepts an enqueue while full when a dequeue fires in the same cycle. Producer and consumer rules connect to it directly, with no extra glue.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_regfile.sv | 36 +++
 rtl/fifo_n_guarded.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the guarded FIFO slice.
//   FIFO_CNT_W(depth)    : width of an occupancy counter holding 0..depth
//   FIFO_PTR_W(depth)    : width of a read/write pointer indexing depth entries
//   fifo_depth_ok(depth) : depth is a power of two and at least 2
package fifo_pkg;

   function automatic int unsigned FIFO_CNT_W(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned FIFO_PTR_W(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic bit fifo_depth_ok(input int unsigned depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH register array, no reset.
//   CLK   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
module fifo_regfile
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 384,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         CLK,
   input  logic                         we,
   input  logic [FIFO_PTR_W(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]             wdata,
   input  logic [FIFO_PTR_W(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]             rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_n_guarded.sv
// fifo_n_guarded: N-entry FIFO with guarded enq/deq/first methods.
//   CLK, nRST      : clock; synchronous active-low reset
//   in_enq__ENA    : enqueue strobe, acts only while in_enq__RDY
//   in_enq_v       : enqueue payload
//   in_enq__RDY    : enqueue permitted (not full, or full with a same-cycle
//                    dequeue when PIPELINED)
//   out_deq__ENA   : dequeue strobe, acts only while out_deq__RDY
//   out_deq__RDY   : FIFO non-empty
//   out_first      : head entry, undefined while empty
//   out_first__RDY : FIFO non-empty
//   count          : occupancy 0..DEPTH
module fifo_n_guarded
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 384,
  parameter int unsigned DEPTH     = 4,
  parameter bit          PIPELINED = 1'b1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_enq__ENA,
  input  logic [WIDTH-1:0]             in_enq_v,
  output logic                         in_enq__RDY,
  input  logic                         out_deq__ENA,
  output logic                         out_deq__RDY,
  output logic [WIDTH-1:0]             out_first,
  output logic                         out_first__RDY,
  output logic [FIFO_CNT_W(DEPTH)-1:0] count
);

  localparam int unsigned PTR_W = FIFO_PTR_W(DEPTH);
  localparam int unsigned CNT_W = FIFO_CNT_W(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_n_guarded: DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, enq, deq;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  assign out_deq__RDY   = !empty;
  assign out_first__RDY = !empty;
  // Pipelined mode frees the slot being dequeued this cycle, so the ready
  // is combinational on the consumer's ENA.
  assign in_enq__RDY    = !full || (PIPELINED && out_deq__ENA);

  assign enq = in_enq__ENA && in_enq__RDY;
  assign deq = out_deq__ENA && out_deq__RDY;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .CLK   (CLK),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (in_enq_v),
    .raddr (rd_ptr_q),
    .rdata (out_first)
  );

  assign count = count_q;

endmodule
